// File: rtl/code_frame_collector.sv
// code_frame_collector: assembles a 6-bit code from a serial bit stream,
// presents it on a..f to a combinational validity checker, waits SETTLE
// cycles, then registers the checker verdict and keeps saturating tallies.
module code_frame_collector #(
    parameter int SETTLE = 2,
    parameter int CW     = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          bit_ready,
    input  logic          clear,
    output logic          a,
    output logic          b,
    output logic          c,
    output logic          d,
    output logic          e,
    output logic          f,
    input  logic          chk_valid,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] pass_count,
    output logic [CW-1:0] fail_count
);

    typedef enum logic {
        COLLECT,
        CHECK
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [5:0] code;
    logic [2:0] idx;
    logic [3:0] settle;

    assign {f, e, d, c, b, a} = code;

    // Reset and clear gate the handshake combinationally so no bit is taken
    // on an edge where either is asserted.
    assign bit_ready = (state == COLLECT) & ~reset & ~clear;

    // Frame collection, settle timing, result capture and tallies.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= COLLECT;
            idx        <= '0;
            settle     <= '0;
            code       <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                COLLECT: begin
                    if (clear) begin
                        idx <= '0;
                    end else if (bit_valid && bit_ready) begin
                        code[idx] <= bit_in;
                        if (idx == 3'd5) begin
                            idx    <= '0;
                            settle <= '0;
                            state  <= CHECK;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                CHECK: begin
                    if (clear) begin
                        idx    <= '0;
                        settle <= '0;
                        state  <= COLLECT;
                    end else if (settle == SETTLE_LAST) begin
                        pass   <= chk_valid;
                        done   <= 1'b1;
                        settle <= '0;
                        state  <= COLLECT;
                        if (chk_valid) begin
                            if (pass_count != '1)
                                pass_count <= pass_count + 1'b1;
                        end else begin
                            if (fail_count != '1)
                                fail_count <= fail_count + 1'b1;
                        end
                    end else begin
                        settle <= settle + 4'd1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_code_frame_collector.sv
// Self-checking bench for code_frame_collector with a one-hot checker model.
module tb_code_frame_collector;

    localparam int SETTLE = 2;
    localparam int CW     = 8;

    logic          clock = 1'b0;
    logic          reset, bit_in, bit_valid, bit_ready, clear;
    logic          a, b, c, d, e, f;
    logic          chk_valid, done, pass;
    logic [CW-1:0] pass_count, fail_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic       exp_pass;
        int         exp_pc;
        int         exp_fc;
        logic [5:0] exp_code;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         m_idx  = 0;
    logic [5:0] m_code = '0;
    int         m_pc   = 0;
    int         m_fc   = 0;
    logic       m_pass = 1'b0;

    code_frame_collector #(.SETTLE(SETTLE), .CW(CW)) dut (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .clear(clear),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .chk_valid(chk_valid), .done(done), .pass(pass),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    // checker stand-in: a code is valid when exactly one bit is set
    assign chk_valid = $onehot({f, e, d, c, b, a});

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // result monitor: every done must match the oldest outstanding frame
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("done_latency", cyc, x.due);
                check("pass", pass, x.exp_pass);
                check("pass_count", pass_count, x.exp_pc);
                check("fail_count", fail_count, x.exp_fc);
                check("code_abcdef", {f, e, d, c, b, a}, x.exp_code);
            end
        end
    end

    task automatic send_bit(input logic bv, input logic commit, output int n);
        n = 0;
        @(negedge clock);
        bit_in = bv;
        bit_valid = 1'b1;
        #1;
        while (!bit_ready && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!bit_ready) begin
            check("ready_timeout", bit_ready, 1'b1);
            return;
        end
        m_code[m_idx] = bv;
        if (m_idx == 5) begin
            m_idx = 0;
            if (commit) begin
                exp_t x;
                m_pass = $onehot(m_code);
                if (m_pass) begin
                    if (m_pc < 255) m_pc++;
                end else begin
                    if (m_fc < 255) m_fc++;
                end
                x.exp_pass = m_pass;
                x.exp_pc   = m_pc;
                x.exp_fc   = m_fc;
                x.exp_code = m_code;
                x.due      = cyc + 1 + SETTLE;
                sb.push_back(x);
            end
        end else begin
            m_idx++;
        end
    endtask

    // sends a full frame (fr[0] = first bit = a); n0 = wait before first bit
    task automatic send_frame(input logic [5:0] fr, input logic commit, output int n0);
        int n;
        for (int unsigned i = 0; i < 6; i++) begin
            send_bit(fr[i], commit, n);
            if (i == 0) n0 = n;
        end
    endtask

    task automatic idle(input int k);
        @(negedge clock);
        bit_valid = 1'b0;
        repeat (k) @(negedge clock);
    endtask

    task automatic drain;
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ready", bit_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_code", {f, e, d, c, b, a}, 6'd0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_pc", pass_count, 0);
        check("rst_fc", fail_count, 0);
        check("ready_after_rst", bit_ready, 1'b1);

        // single passing then failing frame
        send_frame(6'b000001, 1'b1, n);
        idle(5);
        send_frame(6'b000000, 1'b1, n);
        idle(5);
        drain();

        // back-to-back frames: ready gap equals the settle window
        send_frame(6'b000001, 1'b1, n);
        send_frame(6'b000000, 1'b1, n);
        check("b2b_gap1", n, SETTLE);
        send_frame(6'b100000, 1'b1, n);
        check("b2b_gap2", n, SETTLE);
        idle(5);
        drain();

        // clear part-way through collection, then a full frame
        for (int unsigned i = 0; i < 3; i++) send_bit(1'b1, 1'b1, n);
        idle(1);
        clear = 1'b1;
        #1;
        check("clear_ready", bit_ready, 1'b0);
        @(negedge clock);
        clear = 1'b0;
        m_idx = 0;
        send_frame(6'b000010, 1'b1, n);
        idle(5);
        drain();

        // clear during the settle window abandons the frame
        send_frame(6'b000100, 1'b0, n);
        @(negedge clock);
        bit_valid = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (5) @(negedge clock);
        check("abort_pc", pass_count, m_pc);
        check("abort_fc", fail_count, m_fc);
        check("abort_pass", pass, m_pass);
        check("abort_ready", bit_ready, 1'b1);

        // drive pass_count to saturation and one beyond
        while (m_pc < 255) send_frame(6'b000001, 1'b1, n);
        send_frame(6'b010000, 1'b1, n);
        idle(5);
        drain();
        check("sat_pc", pass_count, 255);
        check("sat_pass", pass, 1'b1);

        // reset together with clear in the middle of a settle window
        send_frame(6'b000001, 1'b0, n);
        @(negedge clock);
        bit_valid = 1'b0;
        reset = 1'b1;
        clear = 1'b1;
        @(negedge clock);
        check("mid_rst_code", {f, e, d, c, b, a}, 6'd0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_pass", pass, 1'b0);
        check("mid_rst_pc", pass_count, 0);
        check("mid_rst_fc", fail_count, 0);
        check("mid_rst_ready", bit_ready, 1'b0);
        @(negedge clock);
        check("mid_rst_ready2", bit_ready, 1'b0);
        reset = 1'b0;
        clear = 1'b0;
        #1;
        check("post_rst_ready", bit_ready, 1'b1);
        m_idx = 0; m_code = '0; m_pc = 0; m_fc = 0; m_pass = 1'b0;
        repeat (4) @(negedge clock);
        check("post_rst_done", done, 1'b0);

        // fresh frame after reset counts from zero
        send_frame(6'b000000, 1'b1, n);
        idle(5);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
